// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources; owns the baud selector.
// Latency: Request sampled in IDLE -> Grant/TxStart/TxData registered next cycle; rate ack 1 cycle after acceptance.
// Backpressure: Request/RateChangeRequest are held levels, sampled only in IDLE while TxBusy is low.
module uart_tx_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int BUSY_TIMEOUT  = 15
) (
  input  logic                          Clock,
  input  logic                          ResetN,
  input  logic [NUM_REQ-1:0]            Request,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] RequestData,
  output logic [NUM_REQ-1:0]            Grant,
  output logic [2:0]                    Owner,
  output logic                          TxStart,
  output logic [DATA_WIDTH-1:0]         TxData,
  input  logic                          TxBusy,
  input  logic                          RateChangeRequest,
  input  logic [1:0]                    NewBaudrate,
  output logic                          RateChangeAck,
  output logic [1:0]                    BaudrateSelector,
  output logic                          Idle,
  output logic                          TxTimeout
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE,
    RECONFIG,
    SETTLE
  } state_t;

  typedef enum logic [1:0] {
    BAUD_1200 = 2'b00,
    BAUD_2400 = 2'b01,
    BAUD_4800 = 2'b10,
    BAUD_9600 = 2'b11
  } baud_t;

  // Everything that describes one issued byte travels together.
  typedef struct packed {
    logic [NUM_REQ-1:0]    grant;
    logic                  start;
    logic [DATA_WIDTH-1:0] data;
    logic [2:0]            owner;
  } txIssue_t;

  localparam logic [3:0] TIMEOUT_LAST = 4'(BUSY_TIMEOUT);
  localparam logic [3:0] SETTLE_LAST  = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] OWNER_RESET  = 3'(NUM_REQ - 1);

  state_t   state;
  state_t   nextState;
  logic [3:0] count;
  logic [3:0] nextCount;
  txIssue_t issue;
  txIssue_t nextIssue;
  baud_t    pendingRate;
  baud_t    nextPendingRate;
  baud_t    baudSel;
  baud_t    nextBaudSel;
  logic     ackReg;
  logic     nextAck;
  logic     timeoutReg;
  logic     nextTimeout;

  logic                  pickValid;
  logic [2:0]            pickIdx;
  logic [NUM_REQ-1:0]    pickOneHot;
  logic [DATA_WIDTH-1:0] pickData;

  // Round-robin pick: the first set Request bit at distance 1..NUM_REQ above the last owner.
  // A requester that was just served is reached last, so continuous demand rotates fairly.
  always_comb begin
    pickValid  = 1'b0;
    pickIdx    = '0;
    pickOneHot = '0;
    pickData   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pickValid && Request[i] && (((int'(issue.owner) + k) % NUM_REQ) == i)) begin
          pickValid     = 1'b1;
          pickIdx       = 3'(i);
          pickOneHot[i] = 1'b1;
          pickData      = RequestData[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Next-state and next-output logic; Grant/TxStart/Ack default low so they are single-cycle pulses.
  always_comb begin
    nextState       = state;
    nextCount       = count;
    nextIssue       = issue;
    nextIssue.grant = '0;
    nextIssue.start = 1'b0;
    nextPendingRate = pendingRate;
    nextBaudSel     = baudSel;
    nextAck         = 1'b0;
    nextTimeout     = timeoutReg;

    case (state)
      IDLE: begin
        // A rate change outranks data so a pending reconfiguration cannot be starved.
        if (RateChangeRequest && !TxBusy) begin
          nextPendingRate = baud_t'(NewBaudrate);
          nextState       = RECONFIG;
        end else if (pickValid && !TxBusy) begin
          nextIssue.grant = pickOneHot;
          nextIssue.start = 1'b1;
          nextIssue.data  = pickData;
          nextIssue.owner = pickIdx;
          nextCount       = '0;
          nextState       = WAIT_BUSY;
        end
      end

      WAIT_BUSY: begin
        if (TxBusy) begin
          nextState = WAIT_DONE;
        end else begin
          nextCount = count + 4'd1;
          // Transmitter never acknowledged: flag it and give up on this byte.
          if ((count + 4'd1) == TIMEOUT_LAST) begin
            nextTimeout = 1'b1;
            nextState   = IDLE;
          end
        end
      end

      WAIT_DONE: begin
        if (!TxBusy) begin
          nextState = IDLE;
        end
      end

      RECONFIG: begin
        // Same-rate requests still go through ack and settle so the handshake is uniform.
        nextBaudSel = pendingRate;
        nextAck     = 1'b1;
        nextCount   = '0;
        nextState   = SETTLE;
      end

      SETTLE: begin
        // Gives the baud generator time to lock onto the new divisor before the next frame.
        if (count == SETTLE_LAST) begin
          nextState = IDLE;
        end else begin
          nextCount = count + 4'd1;
        end
      end

      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset abandons any in-flight byte.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      count       <= '0;
      issue.grant <= '0;
      issue.start <= 1'b0;
      issue.data  <= '0;
      issue.owner <= OWNER_RESET;
      pendingRate <= BAUD_1200;
      baudSel     <= BAUD_1200;
      ackReg      <= 1'b0;
      timeoutReg  <= 1'b0;
    end else begin
      state       <= nextState;
      count       <= nextCount;
      issue       <= nextIssue;
      pendingRate <= nextPendingRate;
      baudSel     <= nextBaudSel;
      ackReg      <= nextAck;
      timeoutReg  <= nextTimeout;
    end
  end

  assign Grant            = issue.grant;
  assign TxStart          = issue.start;
  assign TxData           = issue.data;
  assign Owner            = issue.owner;
  assign BaudrateSelector = baudSel;
  assign RateChangeAck    = ackReg;
  assign TxTimeout        = timeoutReg;
  assign Idle             = (state == IDLE);

endmodule
